// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: one PC in, one memory read in flight, instruction held for the IDU.
// A redirect flushes whatever fetch is in progress or held.
module ifu_fetch_ctrl #(
  parameter int PC_DW   = 32,
  parameter int INST_DW = 32,
  parameter int CNT_DW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_valid,
  input  logic [PC_DW-1:0]   pc,
  output logic               pc_ready,
  input  logic               redirect,
  output logic               mem_req_valid,
  output logic [PC_DW-1:0]   mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_resp_valid,
  input  logic [INST_DW-1:0] mem_resp_data,
  input  logic               mem_resp_err,
  output logic               inst_valid,
  output logic [INST_DW-1:0] inst,
  output logic [PC_DW-1:0]   inst_pc,
  output logic               inst_err,
  input  logic               inst_ready,
  output logic [CNT_DW-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic               r_drop;
  logic [PC_DW-1:0]   r_addr;
  logic [PC_DW-1:0]   r_inst_pc;
  logic [INST_DW-1:0] r_inst;
  logic               r_inst_err;
  logic [CNT_DW-1:0]  r_cnt;

  logic w_pc_ready;
  logic w_pc_acc;
  logic w_deliver;

  assign w_pc_ready = !redirect &&
                      (r_state == S_IDLE ||
                       (r_state == S_HOLD && inst_ready));
  assign w_pc_acc   = pc_valid && w_pc_ready;
  assign w_deliver  = r_state == S_HOLD && inst_ready && !redirect;

  assign pc_ready      = w_pc_ready;
  assign mem_req_valid = r_state == S_REQ;
  assign mem_req_addr  = r_addr;
  assign inst_valid    = r_state == S_HOLD;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_err      = r_inst_err;
  assign fetch_cnt     = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_drop     <= 1'b0;
      r_addr     <= '0;
      r_inst_pc  <= '0;
      r_inst     <= '0;
      r_inst_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_deliver)
        r_cnt <= r_cnt + CNT_DW'(1);
      if (w_pc_acc)
        r_addr <= pc;
      case (r_state)
        S_IDLE: begin
          if (w_pc_acc)
            r_state <= S_REQ;
        end
        S_REQ: begin
          // request stays up after a redirect; its response is dropped later
          if (redirect)
            r_drop <= 1'b1;
          if (mem_req_ready)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_drop <= 1'b0;
            if (r_drop || redirect) begin
              r_state <= S_IDLE;
            end else begin
              r_inst     <= mem_resp_data;
              r_inst_err <= mem_resp_err;
              r_inst_pc  <= r_addr;
              r_state    <= S_HOLD;
            end
          end else if (redirect) begin
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect)
            r_state <= S_IDLE;
          else if (inst_ready)
            r_state <= pc_valid ? S_REQ : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  property p_resp_in_wait;
    @(posedge clk) disable iff (rst)
      mem_resp_valid |-> r_state == S_WAIT;
  endproperty
  a_resp_in_wait: assert property (p_resp_in_wait);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed vector table, flush/reset/wrap
// sequences, then randomized traffic against a transaction-level model.
module tb_ifu_fetch_ctrl;
  localparam int PW = 32;
  localparam int IW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pc_valid = 1'b0;
  logic [PW-1:0] pc = '0;
  logic          pc_ready;
  logic          redirect = 1'b0;
  logic          mem_req_valid;
  logic [PW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic [IW-1:0] mem_resp_data = '0;
  logic          mem_resp_err = 1'b0;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [PW-1:0] inst_pc;
  logic          inst_err;
  logic          inst_ready = 1'b0;
  logic [CW-1:0] fetch_cnt;

  ifu_fetch_ctrl #(.PC_DW(PW), .INST_DW(IW), .CNT_DW(CW)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .redirect(redirect),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err), .inst_ready(inst_ready),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    int          rd;
    int          sd;
    int          hold;
    logic        chain;
    logic [31:0] npc;
    int          lat;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[5];

  // rd: cycles req_ready stays low; sd: extra cycles before resp
  task automatic fetch(input vec_t v, input bit chained);
    int lat;
    if (!chained) begin
      @(negedge clk);
      pc_valid = 1'b1;
      pc = v.pc;
      #1 chk("pc_ready_idle", pc_ready, 1);
      @(posedge clk);
    end
    lat = 0;
    for (int t = 1; t < 40 && lat == 0; t++) begin
      @(negedge clk);
      pc_valid = 1'b0;
      inst_ready = 1'b0;
      mem_req_ready = (t == 1 + v.rd);
      mem_resp_valid = (t == 2 + v.rd + v.sd);
      mem_resp_data = mem_resp_valid ? v.data : 32'h0;
      mem_resp_err = mem_resp_valid ? v.err : 1'b0;
      #1;
      if (t <= 1 + v.rd) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, v.pc);
      end
      if (inst_valid) lat = t;
    end
    chk("latency", lat, v.lat);
    chk("inst", inst, v.data);
    chk("inst_pc", inst_pc, v.pc);
    chk("inst_err", inst_err, v.err);
    repeat (v.hold) begin
      @(negedge clk);
      #1;
      chk("hold_valid", inst_valid, 1);
      chk("hold_pc_ready", pc_ready, 0);
      chk("hold_inst", inst, v.data);
      chk("hold_inst_pc", inst_pc, v.pc);
    end
    @(negedge clk);
    inst_ready = 1'b1;
    pc_valid = v.chain;
    pc = v.npc;
    #1 chk("release_pc_ready", pc_ready, 1);
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    pc_valid = 1'b0;
    chk("after_inst_valid", inst_valid, 0);
    chk("after_req_valid", mem_req_valid, v.chain);
    chk("fetch_cnt", fetch_cnt, v.cnt);
  endtask

  task automatic flush_seq(input logic [31:0] a, input int red_t,
                           input int rdy_t, input int rsp_t,
                           input logic [3:0] cnt);
    bit seen;
    @(negedge clk);
    pc_valid = 1'b1;
    pc = a;
    @(posedge clk);
    seen = 1'b0;
    for (int t = 1; t <= rsp_t + 3; t++) begin
      @(negedge clk);
      pc_valid = 1'b0;
      redirect = (t == red_t);
      mem_req_ready = (t == rdy_t);
      mem_resp_valid = (t == rsp_t);
      mem_resp_data = 32'hdeadbeef;
      #1;
      if (t <= rdy_t) chk("flush_req_held", mem_req_valid, 1);
      if (inst_valid) seen = 1'b1;
    end
    chk("flush_no_inst", seen, 0);
    chk("flush_cnt", fetch_cnt, cnt);
    chk("flush_idle", pc_ready, 1);
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00000013;
  endfunction

  function automatic logic merr(input logic [31:0] a);
    return a[2] ^ a[5];
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t w;
    bit   prev_chain;
    bit   m_fetch, m_reqp, m_flush, m_hold, rsp, e_prdy;
    logic [31:0] m_addr, m_hpc, m_hdata;
    logic        m_herr;
    logic [3:0]  m_cnt;
    int          m_cd;

    tbl[0] = '{32'h80000000, 32'h00000413, 1'b0, 0, 0, 0, 1'b0, 32'h0, 3, 4'd1};
    tbl[1] = '{32'h80000004, 32'h00a00093, 1'b0, 4, 3, 5, 1'b1, 32'h80000010, 10, 4'd2};
    tbl[2] = '{32'h80000010, 32'h12345678, 1'b0, 0, 1, 0, 1'b0, 32'h0, 4, 4'd3};
    tbl[3] = '{32'h80000008, 32'h00000000, 1'b1, 1, 0, 2, 1'b0, 32'h0, 4, 4'd4};
    tbl[4] = '{32'h8000000c, 32'hffffffff, 1'b0, 2, 2, 1, 1'b0, 32'h0, 7, 4'd5};

    #1;
    chk("rst_pc_ready", pc_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", inst_err, 0);
    chk("rst_cnt", fetch_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    prev_chain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch(tbl[i], prev_chain);
      prev_chain = tbl[i].chain;
    end

    flush_seq(32'h80000020, 2, 1, 4, 4'd5);
    w = '{32'h80000100, 32'h00100073, 1'b0, 0, 0, 0, 1'b0, 32'h0, 3, 4'd6};
    fetch(w, 1'b0);
    flush_seq(32'h80000024, 2, 1, 2, 4'd6);
    flush_seq(32'h80000028, 1, 3, 4, 4'd6);

    @(negedge clk);
    pc_valid = 1'b1;
    pc = 32'h8000002c;
    redirect = 1'b1;
    #1 chk("idle_redirect_pc_ready", pc_ready, 0);
    @(posedge clk);
    #1 chk("idle_redirect_no_req", mem_req_valid, 0);
    pc_valid = 1'b0;
    redirect = 1'b0;

    @(negedge clk);
    pc_valid = 1'b1;
    pc = 32'h80000030;
    @(posedge clk);
    @(negedge clk);
    pc_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h11111111;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 chk("hold_redirect_valid", inst_valid, 1);
    inst_ready = 1'b1;
    redirect = 1'b1;
    #1 chk("hold_redirect_pc_ready", pc_ready, 0);
    @(posedge clk);
    #1;
    chk("hold_redirect_flushed", inst_valid, 0);
    chk("hold_redirect_cnt", fetch_cnt, 6);
    inst_ready = 1'b0;
    redirect = 1'b0;

    @(negedge clk);
    pc_valid = 1'b1;
    pc = 32'h80000050;
    @(posedge clk);
    @(negedge clk);
    pc_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_cnt", fetch_cnt, 0);
    chk("arst_pc_ready", pc_ready, 1);
    chk("arst_req_valid", mem_req_valid, 0);
    chk("arst_addr", mem_req_addr, 0);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_inst_pc", inst_pc, 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      w = '{32'h80001000 + 32'(4 * i), 32'(i * 32'h10001), 1'b0,
            0, 0, 0, 1'b0, 32'h0, 3, 4'((i + 1) % 16)};
      fetch(w, 1'b0);
    end

    m_fetch = 0; m_reqp = 0; m_flush = 0; m_hold = 0;
    m_addr = '0; m_hpc = '0; m_hdata = '0; m_herr = 0;
    m_cnt = 4'd0;
    m_cd = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pc_valid = ($urandom_range(0, 9) < 6);
      pc = $urandom & 32'hfffffffc;
      redirect = ($urandom_range(0, 9) == 0);
      inst_ready = ($urandom_range(0, 9) < 6);
      mem_req_ready = ($urandom_range(0, 9) < 6);
      rsp = m_fetch && !m_reqp && m_cd == 0;
      mem_resp_valid = rsp;
      mem_resp_data = rsp ? mdata(m_addr) : $urandom;
      mem_resp_err = rsp ? merr(m_addr) : 1'($urandom);
      #1;
      e_prdy = !redirect &&
               ((!m_fetch && !m_hold) || (m_hold && inst_ready));
      chk("rnd_pc_ready", pc_ready, e_prdy);
      chk("rnd_req_valid", mem_req_valid, m_fetch && m_reqp);
      chk("rnd_inst_valid", inst_valid, m_hold);
      chk("rnd_cnt", fetch_cnt, m_cnt);
      if (m_fetch && m_reqp) chk("rnd_addr", mem_req_addr, m_addr);
      if (m_hold) begin
        chk("rnd_inst", inst, m_hdata);
        chk("rnd_inst_pc", inst_pc, m_hpc);
        chk("rnd_inst_err", inst_err, m_herr);
      end
      if (m_hold) begin
        if (redirect) begin
          m_hold = 0;
        end else if (inst_ready) begin
          m_cnt = m_cnt + 4'd1;
          m_hold = 0;
          if (pc_valid) begin
            m_fetch = 1; m_reqp = 1; m_addr = pc;
          end
        end
      end else if (!m_fetch) begin
        if (pc_valid && !redirect) begin
          m_fetch = 1; m_reqp = 1; m_addr = pc;
        end
      end else if (m_reqp) begin
        if (redirect) m_flush = 1;
        if (mem_req_ready) begin
          m_reqp = 0;
          m_cd = $urandom_range(0, 3);
        end
      end else if (rsp) begin
        m_fetch = 0;
        if (!(m_flush || redirect)) begin
          m_hold = 1;
          m_hpc = m_addr;
          m_hdata = mdata(m_addr);
          m_herr = merr(m_addr);
        end
        m_flush = 0;
        m_cd = -1;
      end else begin
        m_cd--;
        if (redirect) m_flush = 1;
      end
    end
    @(negedge clk);
    pc_valid = 0; redirect = 0; inst_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
